// File: rtl/clock_time_counter_if.sv
// Button/tick inputs and time/mode/display outputs of the clock timekeeping core.
interface clock_time_counter_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [1:0] mode;
    logic       blink;
    logic       day_pulse;

    modport master (
        output tick_1hz, btn_mode, btn_inc,
        input  sec, min, hour, hour_bcd, min_bcd, sec_bcd, mode, blink, day_pulse
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc,
        output sec, min, hour, hour_bcd, min_bcd, sec_bcd, mode, blink, day_pulse
    );
endinterface

// File: rtl/clock_time_counter.sv
// HH:MM:SS 24 h timekeeping core with a two-button set mode and BCD digit outputs.
module clock_time_counter #(
    parameter int unsigned SEC_MAX  = 60,
    parameter int unsigned MIN_MAX  = 60,
    parameter int unsigned HOUR_MAX = 24
) (
    input  logic                 clk_in,
    input  logic                 rst,
    clock_time_counter_if.slave  bus
);
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_e;

    mode_e             mode_q, mode_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic              blink_q, blink_d;
    logic              day_pulse_q, day_pulse_d;
    logic              tick_q, tick_d;
    logic              tick;

    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MAX - 1);
    localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_MAX - 1);
    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX - 1);

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    assign tick = bus.tick_1hz & ~tick_q;

    // Next-state: mode FSM, counting chain and set-mode field increments.
    always_comb begin
        mode_d      = mode_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        blink_d     = blink_q;
        day_pulse_d = 1'b0;
        tick_d      = bus.tick_1hz;

        case (mode_q)
            MODE_RUN: begin
                blink_d = 1'b0;
                if (bus.btn_mode) begin
                    mode_d = MODE_SET_HOUR;
                end
                if (tick) begin
                    if (sec_q == SEC_LAST) begin
                        sec_d = '0;
                        if (min_q == MIN_LAST) begin
                            min_d = '0;
                            if (hour_q == HOUR_LAST) begin
                                hour_d      = '0;
                                day_pulse_d = 1'b1;
                            end else begin
                                hour_d = hour_q + HOUR_W'(1);
                            end
                        end else begin
                            min_d = min_q + MIN_W'(1);
                        end
                    end else begin
                        sec_d = sec_q + SEC_W'(1);
                    end
                end
            end
            MODE_SET_HOUR: begin
                if (bus.btn_mode) begin
                    mode_d  = MODE_SET_MIN;
                    blink_d = 1'b0;
                end else begin
                    if (tick) begin
                        blink_d = ~blink_q;
                    end
                    if (bus.btn_inc) begin
                        hour_d = (hour_q == HOUR_LAST) ? '0 : hour_q + HOUR_W'(1);
                    end
                end
            end
            MODE_SET_MIN: begin
                if (bus.btn_mode) begin
                    mode_d  = MODE_RUN;
                    blink_d = 1'b0;
                    sec_d   = '0;
                end else begin
                    if (tick) begin
                        blink_d = ~blink_q;
                    end
                    if (bus.btn_inc) begin
                        min_d = (min_q == MIN_LAST) ? '0 : min_q + MIN_W'(1);
                    end
                end
            end
            default: begin
                mode_d  = MODE_RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            mode_q      <= MODE_RUN;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            blink_q     <= 1'b0;
            day_pulse_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            blink_q     <= blink_d;
            day_pulse_q <= day_pulse_d;
            tick_q      <= tick_d;
        end
    end

    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.hour      = hour_q;
    assign bus.mode      = mode_q;
    assign bus.blink     = blink_q;
    assign bus.day_pulse = day_pulse_q;
    assign bus.sec_bcd   = to_bcd(sec_q);
    assign bus.min_bcd   = to_bcd(min_q);
    assign bus.hour_bcd  = to_bcd({1'b0, hour_q});
endmodule
